// File: rtl/if_fetch_if.sv
// if_fetch_if: signal bundle between the pipeline/memory side (master) and the IF stage (slave).
interface if_fetch_if;
    logic        rdy;
    logic        jump_enable;
    logic [31:0] jump_target;
    logic [5:0]  stall_ctrler;
    logic        mem_ready;
    logic [31:0] mem_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        if_stall_req;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    modport master (
        output rdy, jump_enable, jump_target, stall_ctrler, mem_ready, mem_inst,
        input  mem_req, mem_addr, if_stall_req, if_pc, if_inst
    );
    modport slave (
        input  rdy, jump_enable, jump_target, stall_ctrler, mem_ready, mem_inst,
        output mem_req, mem_addr, if_stall_req, if_pc, if_inst
    );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch FSM with at most one outstanding memory request.
// Defining ICACHE_EN adds a direct-mapped 64 x 1-word instruction cache.
module if_fetch (
    input logic       clk,
    input logic       rst,
    if_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_e;
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d;
    logic        hit;
    logic [31:0] hit_data;
    logic        unused_ok;
    assign unused_ok = ^bus.stall_ctrler[5:2];
`ifdef ICACHE_EN
    logic [63:0] valid_q;
    logic [23:0] tag_q [64];
    logic [31:0] data_q [64];
    logic        fill;
    assign hit      = valid_q[pc_q[7:2]] && tag_q[pc_q[7:2]] == pc_q[31:8];
    assign hit_data = data_q[pc_q[7:2]];
    // Only a fetch that completes without a redirect may allocate a line.
    assign fill = bus.rdy && state_q == WAIT && bus.mem_ready && !bus.jump_enable;
    always_ff @(posedge clk)
        if (rst) valid_q <= '0;
        else if (fill) valid_q[pc_q[7:2]] <= 1'b1;
    always_ff @(posedge clk)
        if (!rst && fill) begin
            tag_q[pc_q[7:2]]  <= pc_q[31:8];
            data_q[pc_q[7:2]] <= bus.mem_inst;
        end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (bus.jump_enable) begin
            pc_d    = bus.jump_target;
            state_d = ((state_q == WAIT || state_q == DRAIN) && !bus.mem_ready) ? DRAIN : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = hit ? DONE : WAIT;
                    inst_d  = hit ? hit_data : inst_q;
                end
                WAIT: begin
                    state_d = bus.mem_ready ? DONE : WAIT;
                    inst_d  = bus.mem_ready ? bus.mem_inst : inst_q;
                end
                DONE: begin
                    state_d = bus.stall_ctrler[1:0] == 2'b00 ? IDLE : DONE;
                    pc_d    = bus.stall_ctrler[1:0] == 2'b00 ? pc_q + 32'd4 : pc_q;
                end
                default: state_d = bus.mem_ready ? IDLE : DRAIN;
            endcase
        end
    end
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
        end else if (bus.rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    assign bus.mem_req      = state_q == WAIT || (state_q == IDLE && !hit);
    assign bus.mem_addr     = pc_q;
    assign bus.if_stall_req = state_q != DONE;
    assign bus.if_pc        = state_q == DONE ? pc_q : '0;
    assign bus.if_inst      = state_q == DONE ? inst_q : '0;
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The module SHALL have a single clock `clk` and a synchronous, active-high reset `rst`; no other clock or reset exists.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; all state frozen when low
- jump_enable  in  1  redirect from EX
- jump_target  in  32  redirect PC
- stall_ctrler  in  6  stall bus; bit0 = IF stalled, bit1 = ID stalled
- mem_ready  in  1  memory controller has completed the fetch
- mem_inst  in  32  fetched instruction word
- mem_req  out  1  fetch request to memory controller
- mem_addr  out  32  fetch address
- if_stall_req  out  1  IF requests stall (no valid instruction)
- if_pc  out  32  PC presented to IF/ID register
- if_inst  out  32  instruction presented to IF/ID register

Function
REQ-003 The FSM SHALL have states IDLE, WAIT, DONE and DRAIN, plus registers pc[31:0] and inst_buf[31:0].
REQ-004 IDLE: mem_req=1, mem_addr=pc; next state WAIT.
REQ-005 WAIT: mem_req=1, mem_addr=pc, held until mem_ready; on mem_ready, inst_buf<=mem_inst and next state DONE.
REQ-006 DONE: mem_req=0; if stall_ctrler[1]=0 and stall_ctrler[0]=0, pc<=pc+4 (mod 2^32) and next state IDLE; otherwise hold.
REQ-007 DRAIN: mem_req=0; waits for mem_ready; data is discarded; next state IDLE.
REQ-008 if_stall_req SHALL be 1 in IDLE, WAIT and DRAIN, and 0 in DONE.
REQ-009 if_pc SHALL equal pc and if_inst SHALL equal inst_buf in DONE; both SHALL be 0 in every other state.
REQ-010 jump_enable=1 SHALL take priority over all other transitions: pc<=jump_target (bits used unmodified).
- In IDLE or DONE: next state IDLE.
- In WAIT without mem_ready: next state DRAIN.
- In WAIT with mem_ready: data discarded, next state IDLE.
- In DRAIN with mem_ready: next state IDLE.
- In DRAIN without mem_ready: remain in DRAIN.
REQ-011 While rdy=0, all registers SHALL hold their values and outputs SHALL remain stable.
REQ-012 Minimum fetch latency SHALL be 2 cycles (IDLE->WAIT->DONE) with mem_ready arriving in the first WAIT cycle.
REQ-013 pc+4 SHALL wrap from 0xFFFFFFFC to 0x00000000.
REQ-014 At most one memory transaction SHALL be outstanding; mem_req SHALL never be asserted in DRAIN.

Reset
REQ-015 When rst=1 at a clk edge (regardless of rdy): pc=0, inst_buf=0, state=IDLE.
REQ-016 Outputs while rst is held SHALL be mem_req=1, mem_addr=0, if_stall_req=1, if_pc=0, if_inst=0.
REQ-017 Reset mid-transaction SHALL abandon the transaction without draining; the memory controller is reset by the same rst.

Configuration
REQ-018 Macro ICACHE_EN SHALL select the instruction cache, which when defined is direct-mapped, 64 lines x 1 word, index pc[7:2], tag pc[31:8], one valid bit per line.
REQ-019 With ICACHE_EN defined:
- IDLE hit: inst_buf<=line data, mem_req=0, next state DONE (1-cycle fetch).
- IDLE miss: behaves as REQ-004.
- WAIT mem_ready without jump: the line is filled.
- DRAIN: no fill.
- rst: clears all valid bits.
REQ-020 Without ICACHE_EN, no cache storage SHALL exist and every fetch SHALL use memory.

Verification
REQ-021 Reset, then mem_ready=1 with mem_inst=0x00000013 on the 2nd cycle -> DONE with if_pc=0, if_inst=0x00000013, if_stall_req=0; next fetch mem_addr=4.
REQ-022 DONE with stall_ctrler=6'b000010 for 3 cycles -> pc stays 0x10 and if_inst is stable; after release, mem_addr=0x14.
REQ-023 WAIT at pc=0x20 with jump_enable=1, jump_target=0x100 and no mem_ready -> DRAIN; after mem_ready, IDLE with mem_addr=0x100, old word never shown on if_inst.
REQ-024 WAIT with simultaneous mem_ready and jump_enable (target 0x40) -> next state IDLE with mem_addr=0x40, no DRAIN.
REQ-025 rdy=0 for 4 cycles during WAIT with mem_ready pulsed -> no state change; after rdy=1, fetch proceeds normally.
REQ-026 ICACHE_EN: fetch 0x0..0xC, then jump to 0x0 -> hits give a 1-cycle fetch with mem_req=0; access to 0x100 (same index, different tag) misses.
